int2fp_seq: RTL and testbench
=============================

INT2FP_SEQ -- requirements
Module: int2fp_seq

Interface
REQ-001 Parameter NEXP, default 8: exponent field width; only 8 is supported.
REQ-002 Parameter NSIG, default 23: significand field width; only 23 is supported.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand a is valid.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 a  input  32  two's-complement signed integer operand.
REQ-008 out_valid  output  1  result p and flag INEXACT are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 p  output  NEXP+NSIG+1  IEEE-754 single-precision result.
REQ-011 INEXACT  output  1  the result is not exactly equal to a.

Function
REQ-012 The FSM SHALL have states IDLE, NORM, ROUND, DONE and no others.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 An operand is accepted on a cycle with in_valid=1 in IDLE: capture sign=a[31], mag=|a| as a 32-bit unsigned value (0x80000000 -> mag 0x80000000), exp=158.
REQ-015 On acceptance with a=0, go straight to DONE with p=0x00000000 and INEXACT=0 (out_valid on cycle T+1).
REQ-016 On acceptance with a!=0, go to NORM.
REQ-017 NORM: if mag[31]=0, mag<=mag<<1 and exp<=exp-1, stay; if mag[31]=1, go to ROUND. NORM occupies L+1 cycles, where L = leading-zero count of mag.
REQ-018 ROUND, one cycle: mant=mag[30:8], guard=mag[7], sticky=|mag[6:0]; INEXACT<=guard|sticky; apply the rounding of REQ-027/028; go to DONE.
REQ-019 A rounding carry out of mant SHALL set mant=0 and exp=exp+1.
REQ-020 p SHALL be {sign, exp[7:0], mant}; p and INEXACT SHALL be registered and stable throughout DONE.
REQ-021 DONE: hold until out_ready=1, then go to IDLE on the next edge. in_ready is 0 during the DONE cycle, so no same-cycle re-accept.
REQ-022 Nonzero latency: out_valid first asserts L+3 cycles after the acceptance edge (a=1: T+34; |a|>=2^31: T+3).
REQ-023 in_valid SHALL be ignored outside IDLE, and a SHALL NOT be sampled outside IDLE.
REQ-024 OVERFLOW and UNDERFLOW cannot occur for 32-bit inputs and SHALL NOT be ports.

Reset
REQ-025 With rst_n=0 at a clock edge: state=IDLE, in_ready=1, out_valid=0, p=0, INEXACT=0, internal mag/exp/sign=0.
REQ-026 Reset in any state, including mid-NORM or while DONE waits for out_ready, SHALL abort the conversion, discard the result, and produce no out_valid pulse.

Configuration
REQ-027 With ROUND_NEAREST_EN defined: round to nearest, ties to even; increment mant when guard & (sticky | mant[0]).
REQ-028 Without ROUND_NEAREST_EN: truncate toward zero; mant is never incremented. INEXACT is computed identically in both builds.

Verification
REQ-029 a=0x00000001, out_ready=1 -> p=0x3F800000, INEXACT=0, out_valid at T+34; a=0xFFFFFFFF -> p=0xBF800000.
REQ-030 a=0x00000000 -> p=0x00000000, INEXACT=0, out_valid at T+1; a=0x80000000 -> p=0xCF000000, INEXACT=0, out_valid at T+3.
REQ-031 a=0x7FFFFFFF -> with ROUND_NEAREST_EN p=0x4F000000 (carry into exponent), INEXACT=1; without it p=0x4EFFFFFF, INEXACT=1.
REQ-032 a=0x01000001 -> p=0x4B800000, INEXACT=1 in both builds (tie to even); a=0x01000003 -> with ROUND_NEAREST_EN p=0x4B800002, without it p=0x4B800001.
REQ-033 out_ready held 0 for 10 cycles in DONE -> p, INEXACT and out_valid stable, in_ready=0, a second in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst_n=0 for one cycle during NORM of a=1 -> IDLE, in_ready=1, no out_valid; the next operand a=3 converts to p=0x40400000.

Source files
------------

// File: rtl/int2fp_seq.sv
// int2fp_seq: sequential signed 32-bit integer to IEEE-754 single-precision converter.
// Latency: zero -> out_valid one cycle after acceptance; nonzero -> L+3 cycles (L = leading zeros of |a|).
// Backpressure: accepts only in IDLE (in_ready); result held in DONE until out_ready.
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module int2fp_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   p,
  output logic                 INEXACT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic                sign_q;
  logic [31:0]         mag_q;
  logic [7:0]          exp_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [NEXP+NSIG:0]  p_q;
  logic                inexact_q;

  logic [31:0]         mag_abs_d;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [23:0]         mant_sum;
  logic [22:0]         mant_d;
  logic [7:0]          exp_d;
  logic                inexact_d;

  // Magnitude of the incoming operand and the rounding datapath for the normalised magnitude.
  always_comb begin
    mag_abs_d = a[31] ? (~a + 32'd1) : a;
    guard     = mag_q[7];
    sticky    = |mag_q[6:0];
`ifdef ROUND_NEAREST_EN
    round_up  = guard & (sticky | mag_q[8]);
`else
    round_up  = 1'b0;
`endif
    mant_sum  = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    // A carry out of the 23-bit field renormalises: mantissa wraps to zero, exponent bumps.
    mant_d    = mant_sum[23] ? 23'd0 : mant_sum[22:0];
    exp_d     = exp_q + {7'd0, mant_sum[23]};
    inexact_d = guard | sticky;
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      inexact_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= a[31];
            mag_q      <= mag_abs_d;
            // 158 = bias 127 + 31: exponent when the leading one already sits at bit 31.
            exp_q      <= 8'd158;
            in_ready_q <= 1'b0;
            if (a == 32'd0) begin
              p_q         <= '0;
              inexact_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          p_q         <= {sign_q, exp_d, mant_d};
          inexact_q   <= inexact_d;
          exp_q       <= exp_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign INEXACT   = inexact_q;

endmodule

// File: tb/tb_int2fp_seq.sv
// Testbench for int2fp_seq: scoreboard of expected results against an arithmetic reference model.
// Directed vectors, randomized operands with random output backpressure, hold-in-DONE and mid-conversion reset.
module tb_int2fp_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        INEXACT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] p;
    logic        inx;
    int          n;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active = 0;
  bit   force_on = 0;
  bit   force_val = 1;

  int2fp_seq #(.NEXP(8), .NSIG(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .INEXACT   (INEXACT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer readiness: random unless a test pins it.
  initial out_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    out_ready = force_on ? force_val : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact value of the integer, rounded to 24 significant bits with plain arithmetic.
  function automatic void model(input logic [31:0] v, output logic [31:0] pr,
                                output logic ir, output int lat);
    longint m, q, rem, half;
    int     k, e, sh;
    logic   s;
    if (v == 32'd0) begin
      pr = 32'd0; ir = 1'b0; lat = 1;
      return;
    end
    s = v[31];
    m = s ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    k = 0;
    while ((m >> (k + 1)) != 0) k++;
    e   = 127 + k;
    lat = 34 - k;
    if (k <= 23) begin
      q  = m << (23 - k);
      ir = 1'b0;
    end else begin
      sh   = k - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      ir   = (rem != 0);
`ifdef ROUND_NEAREST_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
      if (q == (longint'(1) << 24)) begin
        q = longint'(1) << 23;
        e = e + 1;
      end
    end
    pr = {s, e[7:0], q[22:0]};
  endfunction

  task automatic send(input logic [31:0] v, input bit use_const,
                      input logic [31:0] pc, input logic ic);
    exp_t        e;
    logic [31:0] pm;
    logic        im;
    int          lat;
    bit          ok;
    ok = 0;
    model(v, pm, im, lat);
    e.p   = use_const ? pc : pm;
    e.inx = use_const ? ic : im;
    e.lat = lat;
    e.n   = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a        = v;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.n = cyc + 1;
        sb.push_back(e);
        ok = 1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    chk("accept_in_time", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    chk("drain_in_time", {31'd0, done}, 32'd1);
  endtask

  // Monitor: pop on the first cycle of each result, then require stability while it is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
    end else if (out_valid) begin
      if (!active) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("p", p, cur.p);
          chk("INEXACT", {31'd0, INEXACT}, {31'd0, cur.inx});
          chk("latency", cyc - cur.n + 1, cur.lat);
        end
        active = 1;
      end else begin
        chk("p_stable", p, cur.p);
        chk("INEXACT_stable", {31'd0, INEXACT}, {31'd0, cur.inx});
      end
      chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
      if (out_ready) active = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d cycles required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_p", p, 32'd0);
    chk("reset_INEXACT", {31'd0, INEXACT}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors with expected values written out by hand.
    send(32'h0000_0001, 1, 32'h3F80_0000, 1'b0);
    send(32'hFFFF_FFFF, 1, 32'hBF80_0000, 1'b0);
    send(32'h0000_0000, 1, 32'h0000_0000, 1'b0);
    send(32'h8000_0000, 1, 32'hCF00_0000, 1'b0);
`ifdef ROUND_NEAREST_EN
    send(32'h7FFF_FFFF, 1, 32'h4F00_0000, 1'b1);
    send(32'h0100_0003, 1, 32'h4B80_0002, 1'b1);
`else
    send(32'h7FFF_FFFF, 1, 32'h4EFF_FFFF, 1'b1);
    send(32'h0100_0003, 1, 32'h4B80_0001, 1'b1);
`endif
    send(32'h0100_0001, 1, 32'h4B80_0000, 1'b1);

    // Randomized operands across magnitudes and signs.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom >> $urandom_range(0, 31);
        2: v = -($urandom >> $urandom_range(0, 31));
        default: v = (32'd1 << $urandom_range(0, 31)) | ($urandom & 32'h0000_01FF);
      endcase
      send(v, 0, 32'd0, 1'b0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    drain();

    // Hold the result in DONE for 10 cycles with a competing operand offered.
    force_val = 1'b0;
    force_on  = 1'b1;
    send(32'h0001_2345, 0, 32'd0, 1'b0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("hold_out_valid_seen", {31'd0, seen}, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a        = $urandom;
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    force_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset in the middle of normalising a=1: conversion is abandoned.
    send(32'h0000_0001, 1, 32'h3F80_0000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    send(32'h0000_0003, 1, 32'h4040_0000, 1'b0);
    drain();
    force_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
